button_event_arbiter: RTL

Collects rising-edge events from `N_CH` asynchronous push-button inputs and serialises them onto one valid/ready event port consumed by the interpreter core. Each channel has:
- a 2-flop synchroniser,
- an optional debounce filter,
- a rising-edge detector,
- a one-deep pending latch.

A round-robin arbiter loads one pending channel ID into a registered output slot.

---
 rtl/button_pkg.sv | 21 ++
 rtl/button_event_arbiter_channel.sv | 68 ++++++
 rtl/button_event_arbiter.sv | 100 ++++++++++
 3 files changed

// File: rtl/button_pkg.sv
// Shared constants and types for the push-button event arbiter.
package button_pkg;

    localparam int N_CH_DEFAULT            = 4;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 16;

    // Widest channel index supported (up to 16 channels).
    localparam int ID_W_MAX = 4;

    // Channel index width, never narrower than one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Contents of the registered output slot.
    typedef struct packed {
        logic                valid;
        logic [ID_W_MAX-1:0] id;
    } evt_t;

endpackage

// File: rtl/button_event_arbiter_channel.sv
// One push-button channel: 2-flop synchroniser, optional debounce filter
// and rising-edge detector. Debounce is present only when the macro
// BUTTON_DEBOUNCE_EN is defined; otherwise the stable level is sync2.
module button_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic BTN,
    output logic EDGE
);

    logic sync1;
    logic sync2;
    logic stable;
    logic prev;

    // Bring the asynchronous button level into the clock domain.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= BTN;
            sync2 <= sync1;
        end
    end

`ifdef BUTTON_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic [CNT_W-1:0] cnt;

    // Accept a level change only after it has persisted DEBOUNCE_CYCLES cycles.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            stable <= 1'b0;
            cnt    <= '0;
        end else if (sync2 == stable) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            stable <= sync2;
            cnt    <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    // Without the filter the parameter has no effect.
    localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

    assign stable = sync2;
`endif

    // Remember last cycle's stable level; cleared so a held button fires once after reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            prev <= 1'b0;
        end else begin
            prev <= stable;
        end
    end

    assign EDGE = stable & ~prev;

endmodule

// File: rtl/button_event_arbiter.sv
// Push-button event arbiter top: per-channel pending latches, sticky
// overrun flags, round-robin grant and a registered valid/ready slot.
// Debounce filtering in the channels is enabled by BUTTON_DEBOUNCE_EN.
module button_event_arbiter
    import button_pkg::*;
#(
    parameter  int N_CH            = N_CH_DEFAULT,
    parameter  int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    localparam int ID_W            = id_width(N_CH)
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [N_CH-1:0] BTN,
    output logic            EVT_VALID,
    input  logic            EVT_READY,
    output logic [ID_W-1:0] EVT_ID,
    output logic [N_CH-1:0] OVERRUN,
    input  logic            CLR_OVERRUN
);

    logic [N_CH-1:0] edge_vec;
    logic [N_CH-1:0] pending;
    logic [N_CH-1:0] load_vec;
    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] gnt_id;
    logic            any_pending;
    logic            slot_free;
    logic            load;
    logic            xfer;
    evt_t            slot;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .CLK  (CLK),
            .RST_N(RST_N),
            .BTN  (BTN[i]),
            .EDGE (edge_vec[i])
        );
    end

    // Round-robin pick: scanning downward with last-write-wins yields the
    // first pending channel upward from last_grant+1.
    always_comb begin
        int idx;
        idx    = 0;
        gnt_id = '0;
        for (int k = N_CH; k >= 1; k--) begin
            idx = (int'(last_grant) + k) % N_CH;
            if (pending[idx]) begin
                gnt_id = ID_W'(idx);
            end
        end
    end

    // Slot handshake and one-hot view of the channel being loaded.
    always_comb begin
        any_pending = |pending;
        xfer        = slot.valid & EVT_READY;
        slot_free   = ~slot.valid | EVT_READY;
        load        = slot_free & any_pending;
        load_vec    = '0;
        if (load) begin
            load_vec[gnt_id] = 1'b1;
        end
    end

    // Pending latch: a new edge beats a same-cycle load; lost edges mark overrun, set beats clear.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            pending <= '0;
            OVERRUN <= '0;
        end else begin
            pending <= (pending & ~load_vec) | edge_vec;
            OVERRUN <= (OVERRUN & ~{N_CH{CLR_OVERRUN}}) | (edge_vec & pending & ~load_vec);
        end
    end

    // Output slot: reload on a grant, empty on a transfer with nothing waiting.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            slot       <= '0;
            last_grant <= ID_W'(N_CH - 1);
        end else if (load) begin
            slot.valid <= 1'b1;
            slot.id    <= ID_W_MAX'(gnt_id);
            last_grant <= gnt_id;
        end else if (xfer) begin
            slot.valid <= 1'b0;
        end
    end

    logic unused_slot_id;
    assign unused_slot_id = ^slot.id;

    assign EVT_VALID = slot.valid;
    assign EVT_ID    = slot.id[ID_W-1:0];

endmodule
